lvt_read_return: RTL

//  Read-side return path of the LVT multi-ported hash memory. Per read port: tracks each accepted

---
 rtl/lvt_pkg.sv | 22 ++
 rtl/lvt_rd_fifo.sv | 62 ++++++
 rtl/lvt_read_return.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lvt_pkg.sv
// Shared definitions for the LVT multi-ported hash memory blocks:
// default geometry, derived widths and the common word/select types.
package lvt_pkg;

  localparam int DEF_P          = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_N_PE_BITS  = 2;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int PORT_SEL_W = $clog2(DEF_P);
  localparam int CNT_W      = $clog2(DEF_FIFO_DEPTH) + 1;

  typedef logic [DEF_N_PE_BITS-1:0]  bank_sel_t;
  typedef logic [DEF_DATA_WIDTH-1:0] data_word_t;

  // Occupancy counters must hold 0..depth inclusive, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lvt_rd_fifo.sv
// Per-port return buffer: small synchronous FIFO whose head word is
// presented straight from storage flops, with an occupancy count used by
// the credit logic in the parent.
module lvt_rd_fifo
  import lvt_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int DEPTH      = DEF_FIFO_DEPTH,
  localparam int CNT_BITS   = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_BITS-1:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_pop;

  assign do_pop   = pop & ~empty;
  assign empty    = (count == '0);
  assign full     = (count == CNT_BITS'(DEPTH));
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array; contents need no reset because empty masks the head word.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lvt_read_return.sv
// Read-side return path: per port, tracks accepted reads through the bank
// read latency, picks the bank word named by the LVT and returns it in
// order through a credit-protected buffer.
module lvt_read_return
  import lvt_pkg::*;
#(
  parameter int P          = DEF_P,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_PE_BITS  = DEF_N_PE_BITS,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [P-1:0]                 ren,
  output logic [P-1:0]                 ren_ready,
  input  logic [P*N_PE_BITS-1:0]       lvt_sel,
  input  logic [P*P*DATA_WIDTH-1:0]    bank_rdata,
  output logic [P*DATA_WIDTH-1:0]      rd_data,
  output logic [P-1:0]                 rd_valid,
  input  logic [P-1:0]                 rd_ready,
  output logic [P-1:0]                 sel_err
);

  localparam int                CNT_BITS   = cnt_width(FIFO_DEPTH);
  localparam logic [CNT_BITS:0] CREDIT_LIM = (CNT_BITS+1)'(FIFO_DEPTH);

  for (genvar i = 0; i < P; i++) begin : g_port
    logic [RD_LAT-1:0]      pipe_vld;
    logic [N_PE_BITS-1:0]   pipe_sel [RD_LAT];
    logic [N_PE_BITS-1:0]   sel_in;
    logic [31:0]            sel_in_w;
    logic [31:0]            out_sel_w;
    logic [CNT_BITS-1:0]    inflight;
    logic [CNT_BITS-1:0]    count;
    logic [CNT_BITS:0]      credit_used;
    logic [DATA_WIDTH-1:0]  push_data;
    logic                   acc;
    logic                   push;
    logic                   full;
    logic                   empty;
    logic                   err_q;

    assign sel_in      = lvt_sel[i*N_PE_BITS +: N_PE_BITS];
    assign sel_in_w    = 32'(sel_in);
    assign out_sel_w   = 32'(pipe_sel[RD_LAT-1]);
    assign push        = pipe_vld[RD_LAT-1];
    assign credit_used = {1'b0, inflight} + {1'b0, count};
    assign ren_ready[i] = ~reset & (credit_used < CREDIT_LIM);
    assign acc         = ren[i] & ren_ready[i];
    assign rd_valid[i] = ~empty;
    assign sel_err[i]  = err_q;

    // Valid bits of the latency pipe; cleared on reset so late bank data is dropped.
    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_vld <= '0;
      end else begin
        pipe_vld[0] <= acc;
        for (int s = 1; s < RD_LAT; s++) begin
          pipe_vld[s] <= pipe_vld[s-1];
        end
      end
    end

    // Bank selects travel alongside the valids; only meaningful where valid is set.
    always_ff @(posedge clk) begin
      pipe_sel[0] <= sel_in;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_sel[s] <= pipe_sel[s-1];
      end
    end

    // Pick this reader's copy of the chosen bank; an out-of-range select yields zero.
    always_comb begin
      push_data = '0;
      for (int b = 0; b < P; b++) begin
        if (out_sel_w == 32'(b)) begin
          push_data = bank_rdata[(i*P+b)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    // Reads currently in the latency pipe, counted against the buffer credits.
    always_ff @(posedge clk) begin
      if (reset) begin
        inflight <= '0;
      end else begin
        inflight <= inflight + CNT_BITS'(acc) - CNT_BITS'(push);
      end
    end

    // Sticky flag for any accepted read that named a non-existent bank.
    always_ff @(posedge clk) begin
      if (reset) begin
        err_q <= 1'b0;
      end else if (acc && (sel_in_w >= 32'(P))) begin
        err_q <= 1'b1;
      end
    end

    lvt_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (rd_ready[i]),
      .pop_data  (rd_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .count     (count),
      .full      (full),
      .empty     (empty)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));
    a_inflight_bound: assert property (@(posedge clk) disable iff (reset)
                                       32'(inflight) <= 32'(RD_LAT));
  end

endmodule
